grf_dump: RTL and testbench

Sequential read-out engine for the 32×32 general register file. On a start pulse it walks register addresses 0..31 through one GRF combinational read port and streams each (address, value) pair out over a valid/ready interface. It also accumulates a 32-bit checksum of all streamed values. It sits beside the GRF in the CPU top level and serves the testbench and trace-compare path. The CPU is expected to hold its writeback stalled while `busy` is high.

---
 rtl/grf_dump_if.sv | 12 +
 rtl/grf_dump.sv | 61 ++++++
 tb/tb_grf_dump.sv | 137 +++++++++++++
 3 files changed

// File: rtl/grf_dump_if.sv
// grf_dump_if: GRF combinational read port plus the (address, value) stream handshake
interface grf_dump_if #(parameter int AW = 5, parameter int DW = 32);
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  modport master (output rd_addr, out_valid, out_addr, out_data, out_last, input rd_data, out_ready);
  modport slave  (input rd_addr, out_valid, out_addr, out_data, out_last, output rd_data, out_ready);
endinterface

// File: rtl/grf_dump.sv
// grf_dump: walks GRF addresses 0..NREG-1, streams each (address, value) beat and sums accepted values
module grf_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  grf_dump_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    checksum
);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  state_t state;
  logic [AW-1:0] idx;
  assign bus.rd_addr = idx;
  assign busy = state != IDLE;
  // beat fields are captured in READ so they stay frozen through any backpressure in SEND
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      done          <= 1'b0;
      checksum      <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state    <= READ;
          idx      <= '0;
          checksum <= '0;
        end
        READ: begin
          bus.out_data  <= bus.rd_data;
          bus.out_addr  <= idx;
          bus.out_last  <= idx == AW'(NREG - 1);
          bus.out_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: if (bus.out_ready) begin
          checksum      <= checksum + bus.out_data;
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
          state         <= idx == AW'(NREG - 1) ? FIN : READ;
          done          <= idx == AW'(NREG - 1);
          idx           <= idx == AW'(NREG - 1) ? '0 : idx + 1'b1;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_grf_dump.sv
// tb_grf_dump: directed and randomized dumps checked against a beat-list / sum reference model
module tb_grf_dump;
  localparam int NREG = 32, AW = 5, DW = 32;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done;
  logic [DW-1:0] checksum;
  logic [DW-1:0] grf [NREG];
  logic [DW-1:0] exp_data [NREG];
  int errors = 0, checks = 0, lat;
  grf_dump_if #(.AW(AW), .DW(DW)) bus ();
  assign bus.rd_data = grf[bus.rd_addr];
  always #5 clk = ~clk;
  grf_dump #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .checksum(checksum)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // One dump: the model expects beat b valid from two cycles after the previous handshake
  // until accepted, data as held by the GRF when the beat's read happens, and a plain sum.
  task automatic dump(input bit rnd, input int stall_addr, input int stall_n,
                      input bit restart, input bit mid_reset, output int hs_lat);
    int beat, nv, stalls, held, hs, dones, done_c;
    bit rdy, written;
    logic [DW-1:0] sum;
    beat = 0; nv = 2; stalls = 0; held = 0; hs = -1; dones = 0; done_c = -1; sum = '0; written = 0;
    for (int i = 0; i < NREG; i++) exp_data[i] = grf[i];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 400; c++) begin
      chk("out_valid", bus.out_valid, beat < NREG && c >= nv);
      if (bus.out_valid && beat < NREG) begin
        chk("out_addr", bus.out_addr, beat);
        chk("out_data", bus.out_data, exp_data[beat]);
        chk("out_last", bus.out_last, beat == NREG - 1);
      end
      if (done) begin
        dones++;
        done_c = c;
        chk("busy_in_done", busy, 1);
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk("busy_after_done", busy, 0);
        chk("done_width", done, 0);
        break;
      end
      if (mid_reset && bus.out_valid && bus.out_addr == 10) begin
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        hs_lat = -1;
        return;
      end
      rdy = rnd ? bit'($urandom_range(0, 1)) : !(bus.out_valid && bus.out_addr == AW'(stall_addr) && held < stall_n);
      if (!rnd && !rdy && bus.out_valid) held++;
      start = restart && bus.out_valid && bus.out_addr == 10;
      if (rnd && !written && bus.out_valid && bus.out_addr == 10) begin
        grf[20] = $urandom;
        exp_data[20] = grf[20];
        grf[3] = $urandom;
        written = 1;
      end
      bus.out_ready = rdy;
      if (bus.out_valid && rdy && beat < NREG) begin
        sum += exp_data[beat];
        if (beat == NREG - 1) hs = c;
        beat++;
        nv = c + 2;
      end else if (bus.out_valid) stalls++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("beats", beat, NREG);
    chk("done_count", dones, 1);
    chk("hs_latency", hs, 64 + stalls);
    chk("done_cycle", done_c, hs + 1);
    chk("checksum", checksum, sum);
    hs_lat = hs;
  endtask
  initial begin
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREG; i++) grf[i] = (i == 0) ? 32'h0 : 32'h100 + i;
    repeat (2) @(negedge clk);
    chk("reset_rd_addr", bus.rd_addr, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_addr", bus.out_addr, 0);
    chk("reset_data", bus.out_data, 0);
    chk("reset_last", bus.out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_checksum", checksum, 0);
    reset = 1'b0;
    @(negedge clk);
    dump(0, -1, 0, 0, 0, lat);
    chk("basic_latency", lat, 64);
    chk("basic_checksum", checksum, 32'h0000_20F0);
    @(negedge clk);
    chk("checksum_hold", checksum, 32'h0000_20F0);
    dump(0, 5, 3, 0, 0, lat);
    chk("stall_latency", lat, 67);
    for (int i = 1; i < NREG; i++) grf[i] = 32'hFFFF_FFFF;
    dump(0, -1, 0, 0, 0, lat);
    chk("wrap_checksum", checksum, 32'hFFFF_FFE1);
    for (int i = 1; i < NREG; i++) grf[i] = 32'h100 + i;
    dump(0, -1, 0, 1, 0, lat);
    chk("restart_latency", lat, 64);
    dump(0, -1, 0, 0, 1, lat);
    dump(0, -1, 0, 0, 0, lat);
    chk("after_reset_checksum", checksum, 32'h0000_20F0);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_valid", bus.out_valid, 0);
    dump(0, -1, 0, 0, 0, lat);
    chk("post_rst_start_latency", lat, 64);
    repeat (3) begin
      for (int i = 1; i < NREG; i++) grf[i] = $urandom;
      dump(1, -1, 0, 0, 0, lat);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
